// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: channel state encoding,
// default 100 MHz timing constants and the counter-width helper.
package btn_pkg;

  typedef enum logic [2:0] {
    ST_UP        = 3'd0,
    ST_DOWN_WAIT = 3'd1,
    ST_DOWN      = 3'd2,
    ST_REPEAT    = 3'd3,
    ST_UP_WAIT   = 3'd4
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;

  // Terminal compare is at value-1, so $clog2 of the largest period suffices.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, shared debounce/repeat counter and FSM.
// Auto-repeat is compiled in only when BTN_AUTOREPEAT_EN is defined.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic click_o,
  output logic release_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             click_q, click_d;
  logic             release_q, release_d;
  logic             s;

  assign s = sync2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= ST_UP;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      click_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      click_q   <= click_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    click_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_UP: begin
        level_d = 1'b0;
        if (s) begin
          cnt_d   = '0;
          state_d = ST_DOWN_WAIT;
        end
      end
      ST_DOWN_WAIT: begin
        if (!s) begin
          state_d = ST_UP;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_DOWN;
          cnt_d   = '0;
          click_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DOWN: begin
        if (!s) begin
          cnt_d   = '0;
          state_d = ST_UP_WAIT;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (cnt_q == RD_LAST) begin
            state_d = ST_REPEAT;
            cnt_d   = '0;
            click_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
`else
          // Held without auto-repeat: counter stays frozen, single click per press.
          cnt_d = cnt_q;
`endif
        end
      end
      ST_REPEAT: begin
        if (!s) begin
          cnt_d   = '0;
          state_d = ST_UP_WAIT;
        end else if (cnt_q == RP_LAST) begin
          cnt_d   = '0;
          click_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_UP_WAIT: begin
        // A re-press before release is accepted resumes DOWN silently.
        if (s) begin
          cnt_d   = '0;
          state_d = ST_DOWN;
        end else if (cnt_q == DB_LAST) begin
          state_d   = ST_UP;
          release_d = 1'b1;
          level_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_UP;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign click_o   = click_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_clicker.sv
// N_BTN independent debounced button channels with click/release pulses;
// optional auto-repeat selected by BTN_AUTOREPEAT_EN inside btn_channel.
module btn_clicker
  import btn_pkg::*;
#(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic [N_BTN-1:0] BTN,
  output logic [N_BTN-1:0] LEVEL,
  output logic [N_BTN-1:0] CLICK,
  output logic [N_BTN-1:0] RELEASE
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_i    (CLK),
      .rst_ni   (RESETn),
      .btn_i    (BTN[i]),
      .level_o  (LEVEL[i]),
      .click_o  (CLICK[i]),
      .release_o(RELEASE[i])
    );
  end

endmodule

// File: tb/tb_btn_clicker.sv
// Scoreboard bench for btn_clicker: stimulus queues expected pulse events,
// a negedge monitor pops and compares whenever CLICK or RELEASE is active.
module tb_btn_clicker;

  localparam int N = 5;
  localparam int LAT = 7; // drive at negedge c -> pulse visible at negedge c+7 (DEBOUNCE_CYCLES=4)

  logic         CLK;
  logic         RESETn;
  logic [N-1:0] BTN;
  logic [N-1:0] LEVEL, CLICK, RELEASE;

  typedef struct {
    int           cyc;
    logic [N-1:0] clk;
    logic [N-1:0] rel;
    logic [N-1:0] lvl;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  btn_clicker #(
    .N_BTN(N), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .CLK(CLK), .RESETn(RESETn), .BTN(BTN),
    .LEVEL(LEVEL), .CLICK(CLICK), .RELEASE(RELEASE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d events pending", q.size());
    $fatal(1, "watchdog");
  end

  // Monitor
  always @(negedge CLK) begin
    exp_t e;
    if ((CLICK | RELEASE) != '0) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: cyc=%0d click=%b release=%b level=%b, required no pulse",
                 cyc, CLICK, RELEASE, LEVEL);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || CLICK !== e.clk || RELEASE !== e.rel || LEVEL !== e.lvl) begin
          n_err++;
          $display("FAIL pulse_event: got cyc=%0d click=%b release=%b level=%b, required cyc=%0d click=%b release=%b level=%b",
                   cyc, CLICK, RELEASE, LEVEL, e.cyc, e.clk, e.rel, e.lvl);
        end
      end
    end
  end

  task automatic push(input int c, input logic [N-1:0] ck, input logic [N-1:0] rl,
                      input logic [N-1:0] lv);
    exp_t e;
    e.cyc = c; e.clk = ck; e.rel = rl; e.lvl = lv;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b required %b", nm, act, req);
    end
  endtask

  task automatic drain(input string nm);
    tick(12);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain_%s: %0d expected pulses never seen, required 0", nm, q.size());
      q.delete();
    end
  endtask

  initial begin
    int c0;
    RESETn = 1'b0;
    BTN    = '0;
    tick(3);
    chk("reset_level",   LEVEL,   '0);
    chk("reset_click",   CLICK,   '0);
    chk("reset_release", RELEASE, '0);
    RESETn = 1'b1;
    tick(2);

    // Single press/release on channel 0
    c0 = cyc;
    BTN[0] = 1'b1;
    push(c0 + LAT, 5'b00001, 5'b00000, 5'b00001);
    tick(10);
    chk("t1_level_held", LEVEL, 5'b00001);
    BTN[0] = 1'b0;
    push(cyc + LAT, 5'b00000, 5'b00001, 5'b00000);
    drain("t1");

    // Bounce on channel 1 never accepted
    for (int i = 0; i < 5; i++) begin
      BTN[1] = 1'b1;
      tick(2);
      BTN[1] = 1'b0;
      tick(2);
    end
    tick(10);
    chk("t2_level_bounce", LEVEL, 5'b00000);
    drain("t2");

    // Long hold on channel 2
    c0 = cyc;
    BTN[2] = 1'b1;
    push(c0 + LAT, 5'b00100, 5'b00000, 5'b00100);
`ifdef BTN_AUTOREPEAT_EN
    for (int t = c0 + LAT + 10; t <= c0 + 42; t += 3)
      push(t, 5'b00100, 5'b00000, 5'b00100);
`endif
    tick(20);
    chk("t3_level_hold", LEVEL, 5'b00100);
    tick(20);
    BTN[2] = 1'b0;
    push(cyc + LAT, 5'b00000, 5'b00100, 5'b00000);
    drain("t3");

    // Simultaneous press on 0 and 4, then a 2-cycle low glitch on 0
    c0 = cyc;
    BTN[0] = 1'b1;
    BTN[4] = 1'b1;
    push(c0 + LAT, 5'b10001, 5'b00000, 5'b10001);
    tick(8);
    BTN[0] = 1'b0;
    tick(2);
    BTN[0] = 1'b1;
    tick(3);
    BTN[0] = 1'b0;
    BTN[4] = 1'b0;
    push(cyc + LAT, 5'b00000, 5'b10001, 5'b00000);
    tick(2);
    chk("t4_level_after_glitch", LEVEL, 5'b10001);
    drain("t4");

    // Reset while channel 3 is held and accepted
    c0 = cyc;
    BTN[3] = 1'b1;
    push(c0 + LAT, 5'b01000, 5'b00000, 5'b01000);
    tick(9);
    chk("t5_level_before_reset", LEVEL, 5'b01000);
    RESETn = 1'b0;
    tick(1);
    chk("t5_reset_level",   LEVEL,   '0);
    chk("t5_reset_click",   CLICK,   '0);
    chk("t5_reset_release", RELEASE, '0);
    RESETn = 1'b1;
    push(cyc + LAT, 5'b01000, 5'b00000, 5'b01000);
    tick(10);
    BTN[3] = 1'b0;
    push(cyc + LAT, 5'b00000, 5'b01000, 5'b00000);
    drain("t5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/btn_clicker.md
# btn_clicker

Input-side conditioner for the board demos: takes raw push-button levels (BTNU/BTNL/BTNC/BTNR/BTND) and produces clean, registered per-button signals. For each button it produces a debounced level, a one-cycle CLICK pulse on press, and a one-cycle RELEASE pulse on release. An optional auto-repeat mode re-issues CLICK while a button is held. It feeds the demo top-level mode/step logic, which consumes single-cycle clicks, and replaces ad-hoc per-button click instances.

## Interface
- N_BTN, 5, number of independent button channels
- DEBOUNCE_CYCLES, 1000000, cycles the synchronized input must be stable before a press/release is accepted (10 ms at 100 MHz); must be ≥ 2
- REPEAT_DELAY, 50000000, held cycles after CLICK before the first auto-repeat CLICK; must be ≥ 2
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat CLICKs; must be ≥ 2
- CLK  in  1  system clock; all logic on posedge
- RESETn  in  1  synchronous, active-low reset, sampled on posedge CLK
- BTN  in  N_BTN  raw asynchronous button levels, 1 = pressed
- LEVEL  out  N_BTN  debounced button state
- CLICK  out  N_BTN  one-cycle pulse on accepted press (and on each repeat)
- RELEASE  out  N_BTN  one-cycle pulse on accepted release

## Operation
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Each channel has a 2-flop synchronizer producing s, a counter cnt wide enough for max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD), and a 5-state FSM.
- UP: LEVEL=0. If s=1: cnt←0, go to DOWN_WAIT.
- DOWN_WAIT: if s=0, go to UP (bounce rejected, no pulse). Else cnt++. When cnt==DEBOUNCE_CYCLES-1: go to DOWN, cnt←0, CLICK pulse, LEVEL←1.
- DOWN: if s=0: cnt←0, go to UP_WAIT. Else, with auto-repeat enabled, cnt++. When cnt==REPEAT_DELAY-1: go to REPEAT, cnt←0, CLICK pulse.
- REPEAT: if s=0: cnt←0, go to UP_WAIT. Else cnt++. When cnt==REPEAT_PERIOD-1: cnt←0, CLICK pulse, stay in REPEAT.
- UP_WAIT: LEVEL stays 1. If s=1: cnt←0, go to DOWN, so the repeat delay restarts and no CLICK is issued. Else cnt++. When cnt==DEBOUNCE_CYCLES-1: go to UP, RELEASE pulse, LEVEL←0.
- CLICK and RELEASE are never both high on one channel in the same cycle.
- A button already held when RESETn deasserts is treated as a fresh press and produces a CLICK after the debounce time.

## Timing
- All outputs are registered. Reset values: LEVEL=0, CLICK=0, RELEASE=0. FSM=UP, cnt=0, synchronizer flops=0.
- Press latency: if BTN goes high and stays high, and edge t is the first edge that samples it, CLICK is high in the cycle following edge t+2+DEBOUNCE_CYCLES. LEVEL rises at the same edge.
- Release latency is symmetric: RELEASE pulse and LEVEL fall occur DEBOUNCE_CYCLES+2 edges after BTN is first sampled low.
- Auto-repeat: first repeat CLICK comes REPEAT_DELAY cycles after the press CLICK. Later repeat CLICKs come every REPEAT_PERIOD cycles.
- Asserting RESETn low mid-operation forces reset values at the next edge. No pulse is emitted during or because of reset.
- Counters never wrap, because compare-and-clear occurs at the terminal value.

## Configuration
- BTN_AUTOREPEAT_EN defined: DOWN→REPEAT behaviour as above.
- BTN_AUTOREPEAT_EN undefined: DOWN holds with cnt frozen, the REPEAT state is never entered, exactly one CLICK per press, and the REPEAT_DELAY and REPEAT_PERIOD parameters are ignored.

## Structure
- Shared package btn_pkg holds:
  - the channel state encoding (UP, DOWN_WAIT, DOWN, REPEAT, UP_WAIT);
  - default timing constants (DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD at 100 MHz).
- One sub-module, btn_channel, contains the synchronizer, counter and FSM for a single button. btn_clicker instantiates N_BTN copies via generate.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Reset with BTN=0, then BTN[0] held high from edge 0: CLICK[0] high exactly one cycle after edge 6, LEVEL[0]=1 from then on, and other channels stay 0.
- BTN[1] toggles high/low every 2 cycles for 20 cycles, then stays low: no CLICK, RELEASE or LEVEL activity.
- Auto-repeat with macro on, BTN[2] held 40 cycles: CLICKs after edges 6, 16, 19, 22, …. On release, RELEASE one cycle 6 edges after the first low sample. With macro off: a single CLICK at 6, then only the RELEASE.
- BTN[0] and BTN[4] pressed on the same edge: both CLICKs in the same cycle. A 2-cycle low glitch while in DOWN gives no RELEASE and no second CLICK.
- RESETn pulled low for 1 cycle while BTN[3] is held and LEVEL[3]=1: all outputs 0 next cycle, then a fresh CLICK[3] 6 edges after RESETn returns high.
